// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch/data request ports, the SRAM-side
// drive signals and the registered response outputs of mem_port_arbiter.
//
// Modports:
//   slave  - the arbiter: takes requests and mem_q, drives grants, SRAM
//            controls and the instr/load_data responses.
//   master - the surrounding pipeline/memory: drives requests and mem_q.
interface mem_port_arbiter_if;
  // Instruction fetch side
  logic        f_req;
  logic [29:0] f_pc;
  logic        f_gnt;
  logic        f_stall;

  // Data load/store side
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;

  // To / from memory_stage
  logic        mem_select;
  logic [29:0] mem_pc;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  // Registered responses
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] load_data;
  logic        load_valid;

  modport slave (
    input  f_req, f_pc, d_req, d_we, d_addr, d_wdata, mem_q,
    output f_gnt, f_stall, d_gnt,
    output mem_select, mem_pc, mem_addr, mem_data, mem_wren,
    output instr, instr_valid, load_data, load_valid
  );

  modport master (
    output f_req, f_pc, d_req, d_we, d_addr, d_wdata, mem_q,
    input  f_gnt, f_stall, d_gnt,
    input  mem_select, mem_pc, mem_addr, mem_data, mem_wren,
    input  instr, instr_valid, load_data, load_valid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port arbiter and response pipeline in front of
// memory_stage. Each cycle the shared SRAM port serves either a data
// load/store (priority) or an instruction fetch. The granted access is tagged
// and the word returned on mem_q one cycle later is captured into instr or
// load_data with a one-cycle valid pulse (2-cycle read latency overall).
//
// Ports:
//   clk   - pipeline clock (SRAM latches its address on the same edge)
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.slave: f_req/f_pc/f_gnt/f_stall,
//           d_req/d_we/d_addr/d_wdata/d_gnt, mem_select/mem_pc/mem_addr/
//           mem_data/mem_wren/mem_q, instr/instr_valid, load_data/load_valid
//
// Parameters:
//   MAX_STARVE - consecutive fetch-denied data grants before fetch is forced
//                (1..15, only used by the starvation guard)
//
// Build option:
//   MEM_ARB_STARVE_GUARD_EN - when defined, a 4-bit starvation counter forces
//                             a fetch grant after MAX_STARVE lost contentions.
module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {TagNone, TagFetch, TagLoad, TagStore} tag_e;

  tag_e        tag_q, tag_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        instr_valid_q, instr_valid_d;
  logic        load_valid_q, load_valid_d;
  logic        f_gnt, d_gnt;
  logic        force_fetch;

  // The counter is 4 bits wide, so larger limits could never be reached.
  always_ff @(posedge clk) begin
    assert (MAX_STARVE >= 1 && MAX_STARVE <= 15);
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_fetch = bus.f_req && (starve_q == 4'(MAX_STARVE));

  // Counts data grants that beat a pending fetch; any fetch grant or a
  // dropped fetch request restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (f_gnt || !bus.f_req) begin
      starve_d = '0;
    end else if (bus.d_req && d_gnt) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (force_fetch) begin
        f_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end else if (bus.f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign bus.f_gnt      = f_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.f_stall    = bus.f_req & ~f_gnt;
  assign bus.mem_select = f_gnt;
  assign bus.mem_pc     = bus.f_pc;
  assign bus.mem_addr   = bus.d_addr;
  assign bus.mem_data   = bus.d_wdata;
  assign bus.mem_wren   = d_gnt & bus.d_we;

  // Tag of the access issued this cycle; it names the response on mem_q
  // during the next cycle.
  always_comb begin
    tag_d = TagNone;
    if (f_gnt) begin
      tag_d = TagFetch;
    end else if (d_gnt) begin
      tag_d = bus.d_we ? TagStore : TagLoad;
    end
  end

  // Response capture, driven by the tag of the access issued last cycle.
  always_comb begin
    instr_d       = instr_q;
    load_data_d   = load_data_q;
    instr_valid_d = 1'b0;
    load_valid_d  = 1'b0;
    case (tag_q)
      TagFetch: begin
        instr_d       = bus.mem_q;
        instr_valid_d = 1'b1;
      end
      TagLoad: begin
        load_data_d  = bus.mem_q;
        load_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q         <= TagNone;
      instr_q       <= '0;
      load_data_q   <= '0;
      instr_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
    end else begin
      tag_q         <= tag_d;
      instr_q       <= instr_d;
      load_data_q   <= load_data_d;
      instr_valid_q <= instr_valid_d;
      load_valid_q  <= load_valid_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.load_data   = load_data_q;
  assign bus.load_valid  = load_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed sequences followed by random traffic, all
// checked cycle by cycle against a transaction-level reference model
// (priority rule, a queue of expected responses due two cycles after grant,
// and an SRAM array providing the expected words).
module tb_mem_port_arbiter;

  localparam int unsigned MaxStarve = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GuardOn = 1'b1;
`else
  localparam bit GuardOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_STARVE(MaxStarve)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // memory_stage stand-in: address latched at the edge, word on mem_q next cycle.
  logic [31:0] sram [4096];
  always @(posedge clk) begin
    if (bus.mem_wren) sram[bus.mem_addr[11:0]] <= bus.mem_data;
    bus.mem_q <= sram[bus.mem_select ? bus.mem_pc[11:0] : bus.mem_addr[11:0]];
  end

  // Reference model state
  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       pend_q[$];
  int          cyc;
  int          starve;
  logic [31:0] m_instr, m_load_data;
  logic        m_instr_valid, m_load_valid;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input logic rst, input logic fr, input logic [29:0] pc,
                      input logic dr, input logic we, input logic [29:0] da,
                      input logic [31:0] wd, output logic dg_out);
    logic        exp_fg, exp_dg;
    logic [31:0] word;
    resp_t       r;
    @(negedge clk);
    reset       = rst;
    bus.f_req   = fr;
    bus.f_pc    = pc;
    bus.d_req   = dr;
    bus.d_we    = we;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    #1;
    exp_fg = 1'b0;
    exp_dg = 1'b0;
    if (!rst) begin
      if (GuardOn && fr && starve == int'(MaxStarve)) exp_fg = 1'b1;
      else if (dr) exp_dg = 1'b1;
      else if (fr) exp_fg = 1'b1;
    end
    check("f_gnt", bus.f_gnt, exp_fg);
    check("d_gnt", bus.d_gnt, exp_dg);
    check("f_stall", bus.f_stall, fr & ~exp_fg);
    check("mem_select", bus.mem_select, exp_fg);
    check("mem_wren", bus.mem_wren, exp_dg & we);
    check("mem_pc", bus.mem_pc, pc);
    check("mem_addr", bus.mem_addr, da);
    check("mem_data", bus.mem_data, wd);
    check("instr", bus.instr, m_instr);
    check("instr_valid", bus.instr_valid, m_instr_valid);
    check("load_data", bus.load_data, m_load_data);
    check("load_valid", bus.load_valid, m_load_valid);
    word   = sram[exp_fg ? pc[11:0] : da[11:0]];
    dg_out = exp_dg;
    @(posedge clk);
    m_instr_valid = 1'b0;
    m_load_valid  = 1'b0;
    if (rst) begin
      pend_q.delete();
      m_instr     = '0;
      m_load_data = '0;
      starve      = 0;
    end else begin
      while (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
        r = pend_q.pop_front();
        if (r.is_fetch) begin
          m_instr       = r.data;
          m_instr_valid = 1'b1;
        end else begin
          m_load_data  = r.data;
          m_load_valid = 1'b1;
        end
      end
      if (exp_fg) pend_q.push_back('{is_fetch: 1'b1, data: word, due: cyc + 2});
      else if (exp_dg && !we) pend_q.push_back('{is_fetch: 1'b0, data: word, due: cyc + 2});
      if (exp_fg || !fr) starve = 0;
      else if (dr && exp_dg) starve++;
    end
    cyc++;
  endtask

  logic        dg;
  logic        hold;
  logic        r_dr, r_we, r_fr, r_rst;
  logic [29:0] r_da, r_pc;
  logic [31:0] r_wd;

  initial begin
    reset         = 1'b1;
    bus.f_req     = 1'b0;
    bus.f_pc      = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    cyc           = 0;
    starve        = 0;
    m_instr       = '0;
    m_load_data   = '0;
    m_instr_valid = 1'b0;
    m_load_valid  = 1'b0;
    for (int i = 0; i < 4096; i++) sram[i] = $urandom;
    sram[12'h010] = 32'h2402_0005;

    // Reset, then fetch-only at 0x10
    step(1, 0, 0, 0, 0, 0, 0, dg);
    step(1, 0, 0, 0, 0, 0, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    step(0, 1, 30'h10, 0, 0, 0, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    check("fetch_word", bus.instr, 32'h2402_0005);
    step(0, 0, 0, 0, 0, 0, 0, dg);

    // Store then load of the same word
    step(0, 0, 0, 1, 1, 30'h20, 32'hDEAD_BEEF, dg);
    step(0, 0, 0, 1, 0, 30'h20, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    check("store_load", bus.load_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, dg);

    // Contention, load followed by fetch, back-to-back fetches
    step(0, 1, 30'h3, 1, 0, 30'h7, 0, dg);
    step(0, 1, 30'h3, 0, 0, 30'h7, 0, dg);
    step(0, 1, 30'h0, 0, 0, 0, 0, dg);
    step(0, 1, 30'h1, 0, 0, 0, 0, dg);
    step(0, 1, 30'h2, 0, 0, 0, 0, dg);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, dg);

    // Reset right after a load grant discards the response
    step(0, 0, 0, 1, 0, 30'h44, 0, dg);
    step(1, 1, 30'h5, 1, 1, 30'h45, 32'h1234_5678, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);

    // Held contention: starvation guard pattern (or no fetch at all)
    for (int i = 0; i < 12; i++) step(0, 1, 30'(i), 1, 0, 30'h50, 0, dg);
    step(0, 0, 0, 0, 0, 0, 0, dg);

    // Random traffic; data request held stable until granted
    hold = 1'b0;
    r_dr = 1'b0; r_we = 1'b0; r_da = '0; r_wd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        r_dr = ($urandom_range(0, 2) != 0);
        r_we = $urandom_range(0, 1);
        r_da = {18'($urandom), 12'($urandom_range(0, 31))};
        r_wd = $urandom;
      end
      r_fr  = ($urandom_range(0, 3) != 0);
      r_pc  = {18'($urandom), 12'($urandom_range(0, 31))};
      r_rst = ($urandom_range(0, 99) == 0);
      step(r_rst, r_fr, r_pc, r_dr, r_we, r_da, r_wd, dg);
      hold = r_dr && !dg && !r_rst;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
